user_pulse_capture: RTL

OBI-subordinate pulse-train receiver in the user domain, the measuring counterpart of the pulse generator peripheral. It synchronises an external pulse input and measures the high and low time of every period in clk_i cycles. Each completed period is pushed into a small FIFO that software drains over OBI. It detects end-of-train by a programmable low-time timeout and raises a maskable interrupt.

---
 rtl/user_pulse_capture_pkg.sv | 68 ++++++
 rtl/user_capture_fifo.sv | 55 +++++
 rtl/user_pulse_capture.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/user_pulse_capture_pkg.sv
// Shared types and constants for the pulse-train capture peripheral:
// bus structs, FSM states, register map and bit positions.
package user_pulse_capture_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_TIMEOUT = 5'h04;
  localparam logic [4:0] OFF_STATUS  = 5'h08;
  localparam logic [4:0] OFF_DATA    = 5'h0C;

  localparam int CTRL_ARM    = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_FLUSH  = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STS_OVF   = 5;
  localparam int STS_DONE  = 6;
  localparam int STS_STUCK = 7;

  localparam logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/user_capture_fifo.sv
// Small synchronous FIFO for period measurements; flush beats push,
// and a push into a full FIFO is accepted only alongside a pop.
module user_capture_fifo #(
  parameter  int unsigned DataWidth = 32,
  parameter  int unsigned Depth     = 4,
  localparam int unsigned AW        = $clog2(Depth),
  localparam int unsigned UW        = AW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [UW-1:0]        usage_o
);

  localparam logic [UW-1:0] FULL_CNT = UW'(Depth);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [UW-1:0]        r_cnt;
  logic                 w_do_push, w_do_pop;

  assign full_o    = (r_cnt == FULL_CNT);
  assign empty_o   = (r_cnt == '0);
  assign usage_o   = r_cnt;
  assign data_o    = r_mem[r_rptr];
  assign w_do_pop  = pop_i & ~flush_i & ~empty_o;
  assign w_do_push = push_i & ~flush_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + {{(UW-1){1'b0}}, w_do_push} - {{(UW-1){1'b0}}, w_do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/user_pulse_capture.sv
// OBI-mapped pulse-train receiver: synchronises pulse_i, measures high/low
// time per period, queues results in a FIFO and flags end-of-train.
module user_pulse_capture #(
  parameter user_pulse_capture_pkg::obi_cfg_t ObiCfg = user_pulse_capture_pkg::ObiDefaultConfig,
  parameter type obi_req_t = user_pulse_capture_pkg::obi_req_t,
  parameter type obi_rsp_t = user_pulse_capture_pkg::obi_rsp_t,
  parameter int unsigned FifoDepth = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  input  logic     pulse_i,
  output logic     irq_o
);
  import user_pulse_capture_pkg::*;

  localparam int unsigned IdW = ObiCfg.IdWidth;
  localparam int unsigned UW  = $clog2(FifoDepth) + 1;

  // bus request stage; the response is built from these one cycle later
  logic           r_req, r_we;
  logic [4:0]     r_off;
  logic [31:0]    r_wdata;
  logic [IdW-1:0] r_id;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_off   <= '0;
      r_wdata <= '0;
      r_id    <= '0;
    end else begin
      r_req <= obi_req_i.req;
      if (obi_req_i.req) begin
        r_we    <= obi_req_i.a.we;
        r_off   <= obi_req_i.a.addr[4:0];
        r_wdata <= obi_req_i.a.wdata;
        r_id    <= obi_req_i.a.aid;
      end
    end
  end

  logic w_wr, w_rd, w_ctrl_wr, w_sts_wr;
  logic w_arm, w_abort, w_flush, w_pop;
  logic w_clr_ovf, w_clr_done, w_clr_stuck;
  logic w_full, w_empty;

  assign w_wr        = r_req & r_we;
  assign w_rd        = r_req & ~r_we;
  assign w_ctrl_wr   = w_wr & (r_off == OFF_CTRL);
  assign w_sts_wr    = w_wr & (r_off == OFF_STATUS);
  assign w_arm       = w_ctrl_wr & r_wdata[CTRL_ARM];
  assign w_abort     = w_ctrl_wr & r_wdata[CTRL_ABORT];
  assign w_flush     = w_ctrl_wr & r_wdata[CTRL_FLUSH];
  assign w_clr_ovf   = w_sts_wr & r_wdata[STS_OVF];
  assign w_clr_done  = w_sts_wr & r_wdata[STS_DONE];
  assign w_clr_stuck = w_sts_wr & r_wdata[STS_STUCK];
  assign w_pop       = w_rd & (r_off == OFF_DATA) & ~w_empty;

  logic        r_irq_en;
  logic [15:0] r_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq_en  <= 1'b0;
      r_timeout <= '0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= r_wdata[CTRL_IRQ_EN];
      if (w_wr && r_off == OFF_TIMEOUT) r_timeout <= r_wdata[15:0];
    end
  end

  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_rise, w_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], pulse_i};
      r_prev <= r_sync[1];
    end
  end

  assign w_rise = r_sync[1] & ~r_prev;
  assign w_fall = ~r_sync[1] & r_prev;

  cap_state_e  r_state;
  logic [15:0] r_cnt, r_high_len, r_pcnt;
  logic        r_done, r_stuck, r_ovf, r_irq;
  logic        w_to, w_run, w_push, w_done_set, w_stuck_set, w_ovf_set;
  logic [31:0] w_push_data, w_fifo_rdata;
  logic [UW-1:0] w_usage;

  assign w_to  = (r_timeout != 16'd0) && (r_cnt == r_timeout);
  assign w_run = ~w_abort & ~w_arm;

  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    w_done_set  = 1'b0;
    w_stuck_set = 1'b0;
    if (w_run) begin
      case (r_state)
        ST_HIGH: if (!w_fall && w_to) w_stuck_set = 1'b1;
        ST_LOW: begin
          if (w_rise) begin
            w_push      = 1'b1;
            w_push_data = {r_high_len, r_cnt};
          end else if (w_to) begin
            // zero low time marks the last pulse of a train
            w_push      = 1'b1;
            w_push_data = {r_high_len, 16'h0};
            w_done_set  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_high_len <= '0;
      r_pcnt     <= '0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
    end else if (w_arm) begin
      r_state <= ST_ARMED;
      r_cnt   <= '0;
      r_pcnt  <= '0;
    end else begin
      case (r_state)
        ST_ARMED: if (w_rise) begin
          r_state <= ST_HIGH;
          r_cnt   <= 16'd1;
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_high_len <= r_cnt;
            r_cnt      <= 16'd1;
            r_state    <= ST_LOW;
          end else if (w_to) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_pcnt  <= r_pcnt + 16'd1;
            r_cnt   <= 16'd1;
            r_state <= ST_HIGH;
          end else if (w_to) begin
            r_pcnt  <= r_pcnt + 16'd1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_ovf_set = w_push & w_full & ~w_pop & ~w_flush;

  // hardware set outranks a simultaneous W1C
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done  <= 1'b0;
      r_stuck <= 1'b0;
      r_ovf   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_arm && !w_abort) begin
        r_done  <= 1'b0;
        r_stuck <= 1'b0;
      end else begin
        r_done  <= w_done_set | (r_done & ~w_clr_done);
        r_stuck <= w_stuck_set | (r_stuck & ~w_clr_stuck);
      end
      r_ovf <= w_ovf_set | (r_ovf & ~w_clr_ovf);
      r_irq <= r_irq_en & (r_done | r_ovf | r_stuck);
    end
  end

  assign irq_o = r_irq;

  user_capture_fifo #(
    .DataWidth (32),
    .Depth     (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .data_o  (w_fifo_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .usage_o (w_usage)
  );

  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = DEFAULT_RDATA;
    case (r_off)
      OFF_CTRL:    w_rdata = {28'b0, r_irq_en, 3'b0};
      OFF_TIMEOUT: w_rdata = {16'b0, r_timeout};
      OFF_STATUS:  w_rdata = {r_pcnt, 3'b0, 5'(w_usage), r_stuck, r_done, r_ovf,
                              w_full, w_empty, r_state};
      OFF_DATA:    w_rdata = w_empty ? 32'h0 : w_fifo_rdata;
      default: ;
    endcase
  end

  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = obi_req_i.req;
    obi_rsp_o.rvalid       = r_req;
    obi_rsp_o.r.rdata      = w_rdata;
    obi_rsp_o.r.rid        = r_id;
    obi_rsp_o.r.err        = 1'b0;
    obi_rsp_o.r.r_optional = 1'b0;
  end

endmodule
